// File: rtl/rvfi_serializer.sv
// Collapses several RVFI commit ports per cycle into one in-order retirement stream
// through a small circular buffer; overflowing records are dropped and counted.
package rvfi_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] order;
        logic [31:0] insn;
        logic        trap;
        logic        halt;
        logic        intr;
        logic [31:0] cause;
        logic [1:0]  mode;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [31:0] rd_wdata;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } rvfi_instr_t;

endpackage

module rvfi_serializer #(
    parameter int NR_COMMIT_PORTS = 2,
    parameter int DEPTH           = 8
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  rvfi_pkg::rvfi_instr_t [NR_COMMIT_PORTS-1:0] rvfi_i,
    output rvfi_pkg::rvfi_instr_t                       rvfi_o,
    output logic                                        valid_o,
    input  logic                                        ready_i,
    output logic [$clog2(DEPTH):0]                      count_o,
    output logic                                        overflow_o,
    output logic [15:0]                                 drop_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    // Sum width holds DEPTH plus every port's candidate without wrapping.
    localparam int SW = AW + 2;

    rvfi_pkg::rvfi_instr_t r_mem [DEPTH];

    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic [15:0]   r_drop_cnt;

    logic                       w_valid;
    logic                       w_pop;
    logic [SW-1:0]              w_free;
    logic [SW-1:0]              w_ncand;
    logic [SW-1:0]              w_written;
    logic [SW-1:0]              w_dropped;
    logic [NR_COMMIT_PORTS-1:0] w_we;
    logic [AW-1:0]              w_off [NR_COMMIT_PORTS];

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [SW-1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + 17'(b);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && ready_i;
    assign w_free  = SW'(DEPTH) - SW'(r_count) + SW'(w_pop);

    // Candidates are packed in port order; the first ones that fit win a slot.
    always_comb begin
        w_ncand   = '0;
        w_written = '0;
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            w_we[i]  = 1'b0;
            w_off[i] = '0;
            if (rvfi_i[i].valid || rvfi_i[i].trap) begin
                if (w_ncand < w_free) begin
                    w_we[i]   = 1'b1;
                    w_off[i]  = AW'(w_ncand);
                    w_written = w_written + SW'(1);
                end
                w_ncand = w_ncand + SW'(1);
            end
        end
        w_dropped = w_ncand - w_written;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_wr_ptr   <= r_wr_ptr + AW'(w_written);
            r_rd_ptr   <= r_rd_ptr + AW'(w_pop);
            r_count    <= CW'(SW'(r_count) + w_written - SW'(w_pop));
            r_drop_cnt <= sat_add16(r_drop_cnt, w_dropped);
            if (w_dropped != '0) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage carries no reset; occupancy alone decides what is live.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            if (w_we[i]) begin
                r_mem[r_wr_ptr + w_off[i]] <= rvfi_i[i];
            end
        end
    end

    assign valid_o    = w_valid;
    assign rvfi_o     = w_valid ? r_mem[r_rd_ptr] : '0;
    assign count_o    = r_count;
    assign overflow_o = r_overflow;
    assign drop_cnt_o = r_drop_cnt;

endmodule

// File: doc/rvfi_serializer.md
RVFI_SERIALIZER -- requirements
Module: rvfi_serializer

Interface
REQ-001 SHALL have parameter NR_COMMIT_PORTS, default 2: number of RVFI commit ports sampled per cycle.
REQ-002 SHALL have parameter DEPTH, default 8: buffer entries; power of two, >= NR_COMMIT_PORTS.
REQ-003 SHALL have port clk_i  input  1  the single clock; all state on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rvfi_i  input  rvfi_pkg::rvfi_instr_t[NR_COMMIT_PORTS-1:0]  commit ports from core; port 0 is oldest.
REQ-006 SHALL have port rvfi_o  output  rvfi_pkg::rvfi_instr_t  single in-order retirement record to tracer.
REQ-007 SHALL have port valid_o  output  1  rvfi_o holds a buffered record.
REQ-008 SHALL have port ready_i  input  1  consumer accepts rvfi_o this cycle.
REQ-009 SHALL have port count_o  output  $clog2(DEPTH)+1  current occupancy.
REQ-010 SHALL have port overflow_o  output  1  sticky: at least one record dropped since reset.
REQ-011 SHALL have port drop_cnt_o  output  16  saturating count of dropped records.

Function
REQ-012 SHALL treat port i as a capture candidate when rvfi_i[i].valid or rvfi_i[i].trap is 1; other ports ignored.
REQ-013 SHALL capture candidates compacted in ascending port order into consecutive buffer slots in the same clock edge.
REQ-014 SHALL define pop = valid_o && ready_i; valid_o = (count_o != 0).
REQ-015 SHALL compute free slots per cycle as DEPTH - count_q + pop (a slot popped this cycle is reusable same edge).
REQ-016 SHALL, when candidates > free, write the lowest-index candidates that fit and drop the rest.
REQ-017 SHALL set overflow_o on the edge following any drop; held until reset.
REQ-018 SHALL add the number dropped to drop_cnt_o each cycle, saturating at 16'hFFFF.
REQ-019 SHALL update count_q <= count_q + written - pop; never exceed DEPTH nor underflow.
REQ-020 SHALL drive rvfi_o from the head slot when valid_o = 1 and all-zero when valid_o = 0.
REQ-021 SHALL have latency 1: record captured at edge N visible on rvfi_o from edge N (after it) if buffer was empty; never combinational pass-through.
REQ-022 SHALL preserve record order: port order within a cycle, cycle order across cycles.
REQ-023 SHALL wrap read and write pointers modulo DEPTH with no lost or duplicated entry at wrap.
REQ-024 SHALL ignore ready_i when valid_o = 0 (no pointer movement).
REQ-025 SHALL copy all rvfi_instr_t fields unmodified.

Reset
REQ-026 SHALL on rst_ni = 0 asynchronously clear read/write pointers, count_q, overflow_o, drop_cnt_o.
REQ-027 SHALL have outputs during and after reset: valid_o = 0, rvfi_o = 0, count_o = 0, overflow_o = 0, drop_cnt_o = 0.
REQ-028 SHALL discard buffered records on reset mid-operation; storage array need not be reset.
REQ-029 SHALL not capture rvfi_i while rst_ni = 0.

Verification
REQ-030 SHALL cover: ports 0,1 valid (pc A, B), ready_i=1 -> rvfi_o = A next cycle, B the cycle after, then valid_o=0.
REQ-031 SHALL cover: only port 1 valid with trap=1, cause=2 -> one record, trap=1, cause=2, count_o=1 for one cycle.
REQ-032 SHALL cover: ready_i=0, 2 records/cycle for 5 cycles (DEPTH=8) -> count_o=8 after cycle 4; cycle 5 drops 2; overflow_o=1, drop_cnt_o=2; drained order = first 8 records.
REQ-033 SHALL cover: count_o=7, ready_i=1, 2 candidates -> both written (free=2), count_o stays 8... checks 7+2-1=8, drop_cnt_o=0.
REQ-034 SHALL cover: 20 records streamed with ready_i toggling randomly -> output sequence identical to input order across pointer wrap.
REQ-035 SHALL cover: rst_ni low with count_o=5 -> valid_o=0, count_o=0, overflow_o=0 immediately (asynchronous), no stale record after release.
